ps2_mouse_rx: RTL and testbench

Device-to-host PS/2 receiver and mouse packet assembler. It sits directly downstream of the host transmitter that sends the 0xF4 enable-reporting command.
- Samples device-clocked 11-bit frames on the shared ps2clk/ps2data lines.
- Detects the 0xFA acknowledge.
- Assembles standard 3-byte movement packets into button and signed X/Y outputs for the tracking-motor control logic.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_rx_frame.sv | 120 ++++++++++++
 rtl/ps2_mouse_rx.sv | 133 +++++++++++++
 tb/tb_ps2_mouse_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, byte-0 field positions and FSM state encodings.
package ps2_pkg;

  localparam logic [7:0]  PS2_ACK           = 8'hFA;
  localparam logic [7:0]  PS2_CMD_EN_REPORT = 8'hF4;
  localparam int unsigned PS2_FRAME_BITS    = 11;
  localparam int unsigned PS2_DATA_BITS     = PS2_FRAME_BITS - 3;

  localparam int unsigned BTN_MSB = 2;
  localparam int unsigned BTN_LSB = 0;
  localparam int unsigned ALIGN   = 3;
  localparam int unsigned XS      = 4;
  localparam int unsigned YS      = 5;
  localparam int unsigned XO      = 6;
  localparam int unsigned YO      = 7;

  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_PARITY,
    F_STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    P_WAIT_ACK,
    P_B0,
    P_B1,
    P_B2
  } pkt_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: line synchronizers, 11-bit frame FSM, bit timeout.
// Parity is enforced only when PS2_RX_PARITY_CHECK_EN is defined.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned BIT_TIMEOUT_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       host_busy,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned TO_W = $clog2(BIT_TIMEOUT_TICKS + 1);

  frame_state_t    state, state_nxt;
  logic [2:0]      clk_sync;
  logic [1:0]      dat_sync;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [TO_W-1:0] to_cnt;
  logic            fall, din, timeout, parity_ok;
  logic            load_byte, err_set;

  // [1] is the second sync flop, [2] the extra flop used only for edge detection
  assign fall    = !clk_sync[1] && clk_sync[2];
  assign din     = dat_sync[1];
  assign timeout = (to_cnt == TO_W'(BIT_TIMEOUT_TICKS));

`ifdef PS2_RX_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      par_bit <= 1'b0;
    end else if (fall && state == F_PARITY) begin
      par_bit <= din;
    end
  end

  assign parity_ok = ^{shreg, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      state    <= F_IDLE;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2clk};
      dat_sync <= {dat_sync[0], ps2data};
      state    <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (host_busy || timeout) begin
      state_nxt = F_IDLE;
    end else if (fall) begin
      case (state)
        F_IDLE:   if (!din) state_nxt = F_DATA;
        F_DATA:   if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_nxt = F_PARITY;
        F_PARITY: state_nxt = F_STOP;
        F_STOP:   state_nxt = F_IDLE;
        default:  state_nxt = F_IDLE;
      endcase
    end
  end

  always_comb begin
    load_byte = 1'b0;
    err_set   = 1'b0;
    if (!host_busy) begin
      if (timeout) begin
        err_set = 1'b1;
      end else if (fall && state == F_STOP) begin
        if (din && parity_ok) load_byte = 1'b1;
        else                  err_set   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      to_cnt     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= load_byte;
      frame_err  <= err_set;
      if (load_byte) rx_byte <= shreg;

      if (fall && state == F_IDLE) begin
        bit_cnt <= '0;
      end else if (fall && state == F_DATA) begin
        shreg   <= {din, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      // a fall in the same cycle as a tick takes priority and clears the count
      if (host_busy || timeout || state == F_IDLE || fall) begin
        to_cnt <= '0;
      end else if (tick) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver top: frame receiver plus 3-byte packet assembler and inter-byte gap timer.
// Optional build macro: PS2_RX_PARITY_CHECK_EN (enforces odd parity on received frames).
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int unsigned BIT_TIMEOUT_TICKS = 8,
  parameter int unsigned PKT_GAP_TICKS     = 67
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       host_busy,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       ack_rcvd,
  output logic       pkt_valid,
  output logic [2:0] btn,
  output logic [8:0] x_mov,
  output logic [8:0] y_mov,
  output logic [1:0] ovf,
  output logic       frame_err
);

  localparam int unsigned GAP_W = $clog2(PKT_GAP_TICKS + 1);

  pkt_state_t       pstate, pstate_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_hit, in_pkt, abort;
  logic             ack_set, store_b0, store_b1, pkt_set;
  logic [2:0]       b0_btn;
  logic             b0_xs, b0_ys;
  logic [1:0]       b0_ovf;
  logic [7:0]       b1;

  ps2_rx_frame #(
    .BIT_TIMEOUT_TICKS(BIT_TIMEOUT_TICKS)
  ) u_frame (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .host_busy (host_busy),
    .ps2clk    (ps2clk),
    .ps2data   (ps2data),
    .rx_byte   (rx_byte),
    .byte_valid(rx_byte_valid),
    .frame_err (frame_err)
  );

  assign gap_hit = (gap_cnt == GAP_W'(PKT_GAP_TICKS));
  assign in_pkt  = (pstate == P_B1) || (pstate == P_B2);
  assign abort   = in_pkt && (gap_hit || frame_err);

  always_ff @(posedge clk) begin
    if (!reset) pstate <= P_WAIT_ACK;
    else        pstate <= pstate_nxt;
  end

  always_comb begin
    pstate_nxt = pstate;
    if (host_busy) begin
      pstate_nxt = P_WAIT_ACK;
    end else if (abort) begin
      pstate_nxt = P_B0;
    end else if (rx_byte_valid) begin
      case (pstate)
        P_WAIT_ACK: if (rx_byte == PS2_ACK) pstate_nxt = P_B0;
        P_B0:       if (rx_byte[ALIGN])     pstate_nxt = P_B1;
        P_B1:       pstate_nxt = P_B2;
        P_B2:       pstate_nxt = P_B0;
        default:    pstate_nxt = P_WAIT_ACK;
      endcase
    end
  end

  always_comb begin
    ack_set  = 1'b0;
    store_b0 = 1'b0;
    store_b1 = 1'b0;
    pkt_set  = 1'b0;
    if (!host_busy && !abort && rx_byte_valid) begin
      case (pstate)
        P_WAIT_ACK: ack_set  = (rx_byte == PS2_ACK);
        P_B0:       store_b0 = rx_byte[ALIGN];
        P_B1:       store_b1 = 1'b1;
        P_B2:       pkt_set  = 1'b1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_rcvd  <= 1'b0;
      pkt_valid <= 1'b0;
      b0_btn    <= '0;
      b0_xs     <= 1'b0;
      b0_ys     <= 1'b0;
      b0_ovf    <= '0;
      b1        <= '0;
      btn       <= '0;
      x_mov     <= '0;
      y_mov     <= '0;
      ovf       <= '0;
      gap_cnt   <= '0;
    end else begin
      ack_rcvd  <= ack_set;
      pkt_valid <= pkt_set;
      if (store_b0) begin
        b0_btn <= rx_byte[BTN_MSB:BTN_LSB];
        b0_xs  <= rx_byte[XS];
        b0_ys  <= rx_byte[YS];
        b0_ovf <= {rx_byte[YO], rx_byte[XO]};
      end
      if (store_b1) b1 <= rx_byte;
      // byte 2 is taken straight from the receiver so outputs change with pkt_valid
      if (pkt_set) begin
        btn   <= b0_btn;
        x_mov <= {b0_xs, b1};
        y_mov <= {b0_ys, rx_byte};
        ovf   <= b0_ovf;
      end

      if (host_busy || abort || rx_byte_valid || !in_pkt) begin
        gap_cnt <= '0;
      end else if (tick) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed self-checking bench for ps2_mouse_rx: ACK, packets, parity, timeouts, host_busy and reset.
module tb_ps2_mouse_rx;

  logic       clk = 1'b0;
  logic       reset, tick, host_busy, ps2clk, ps2data;
  logic [7:0] rx_byte;
  logic       rx_byte_valid, ack_rcvd, pkt_valid, frame_err;
  logic [2:0] btn;
  logic [8:0] x_mov, y_mov;
  logic [1:0] ovf;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  int          n_rx = 0, n_ack = 0, n_pkt = 0, n_ferr = 0, pkt_cyc = 0;
  logic [7:0]  last_rx = '0;

  ps2_mouse_rx #(
    .BIT_TIMEOUT_TICKS(8),
    .PKT_GAP_TICKS    (67)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .host_busy    (host_busy),
    .ps2clk       (ps2clk),
    .ps2data      (ps2data),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .ack_rcvd     (ack_rcvd),
    .pkt_valid    (pkt_valid),
    .btn          (btn),
    .x_mov        (x_mov),
    .y_mov        (y_mov),
    .ovf          (ovf),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_byte_valid) begin
      n_rx    <= n_rx + 1;
      last_rx <= rx_byte;
    end
    if (ack_rcvd) n_ack <= n_ack + 1;
    if (pkt_valid) begin
      n_pkt   <= n_pkt + 1;
      pkt_cyc <= cyc;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
  end

  // one tick every 20 clocks keeps each 20-clock PS/2 bit within a single tick
  initial begin
    tick = 1'b0;
    forever begin
      repeat (19) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par,
                            input int unsigned nfalls, output int stop_cyc);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ flip_par, d, 1'b0};
    stop_cyc = 0;
    for (int unsigned i = 0; i < nfalls; i++) begin
      ps2data = f[i];
      repeat (5) @(negedge clk);
      ps2clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (10) @(negedge clk);
      ps2clk = 1'b1;
      repeat (5) @(negedge clk);
    end
    ps2data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    int sc;
    send_frame(d, 1'b0, 11, sc);
  endtask

  initial begin
    int sc;
    int b_rx, b_ack, b_pkt, b_ferr;

    reset = 1'b0; host_busy = 1'b1; ps2clk = 1'b1; ps2data = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_pulses", {rx_byte_valid, ack_rcvd, pkt_valid, frame_err}, 4'b0000);
    check("rst_btn_ovf", {btn, ovf}, 5'b0);
    check("rst_xy", {x_mov, y_mov}, 18'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    host_busy = 1'b0;
    repeat (5) @(negedge clk);

    send(8'hFA);
    check("ack_rx_cnt", n_rx, 1);
    check("ack_rx_byte", last_rx, 8'hFA);
    check("ack_cnt", n_ack, 1);
    check("ack_no_err", n_ferr, 0);

    send(8'h28);
    send(8'h05);
    send_frame(8'hFB, 1'b0, 11, sc);
    check("pkt1_cnt", n_pkt, 1);
    check("pkt1_btn", btn, 3'b000);
    check("pkt1_x", x_mov, 9'h005);
    check("pkt1_y", y_mov, 9'h1FB);
    check("pkt1_ovf", ovf, 2'b00);
    check("pkt1_latency", pkt_cyc - sc, 4);

    b_rx = n_rx; b_ferr = n_ferr;
    send_frame(8'h05, 1'b1, 11, sc);
`ifdef PS2_RX_PARITY_CHECK_EN
    check("par_err", n_ferr - b_ferr, 1);
    check("par_no_rx", n_rx - b_rx, 0);
`else
    check("par_rx_cnt", n_rx - b_rx, 1);
    check("par_rx_byte", last_rx, 8'h05);
    check("par_no_err", n_ferr - b_ferr, 0);
`endif

    b_rx = n_rx; b_ferr = n_ferr;
    send_frame(8'hA5, 1'b0, 5, sc);
    repeat (250) @(negedge clk);
    check("to_err", n_ferr - b_ferr, 1);
    check("to_no_rx", n_rx - b_rx, 0);
    b_ferr = n_ferr;
    send(8'h09);
    check("to_next_rx_cnt", n_rx - b_rx, 1);
    check("to_next_rx_byte", last_rx, 8'h09);
    check("to_next_no_err", n_ferr - b_ferr, 0);

    // 0x09 above started a packet; let the gap timer drop it before resync test
    repeat (1500) @(negedge clk);
    b_pkt = n_pkt;
    send(8'h01);
    send(8'h09);
    send(8'h10);
    send(8'h20);
    check("resync_pkt_cnt", n_pkt - b_pkt, 1);
    check("resync_btn", btn, 3'b001);
    check("resync_x", x_mov, 9'h010);
    check("resync_y", y_mov, 9'h020);

    b_rx = n_rx; b_ack = n_ack; b_pkt = n_pkt;
    host_busy = 1'b1;
    send(8'hFA);
    check("busy_no_rx", n_rx - b_rx, 0);
    check("busy_no_ack", n_ack - b_ack, 0);
    host_busy = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h09);
    send(8'h10);
    send(8'h20);
    check("busy_wait_rx", n_rx - b_rx, 3);
    check("busy_wait_no_pkt", n_pkt - b_pkt, 0);
    check("busy_wait_no_ack", n_ack - b_ack, 0);
    send(8'hFA);
    check("reack", n_ack - b_ack, 1);

    send(8'hDF);
    send(8'h80);
    send(8'h7F);
    check("pkt3_cnt", n_pkt - b_pkt, 1);
    check("pkt3_btn", btn, 3'b111);
    check("pkt3_x", x_mov, 9'h180);
    check("pkt3_y", y_mov, 9'h07F);
    check("pkt3_ovf", ovf, 2'b11);

    send(8'h08);
    send(8'h11);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_xy", {x_mov, y_mov}, 18'h0);
    check("mid_rst_btn_ovf", {btn, ovf}, 5'b0);
    check("mid_rst_rx_byte", rx_byte, 8'h00);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    b_pkt = n_pkt; b_ack = n_ack;
    send(8'h22);
    send(8'h33);
    send(8'h44);
    check("post_rst_rx_byte", rx_byte, 8'h44);
    check("post_rst_no_pkt", n_pkt - b_pkt, 0);
    check("post_rst_no_ack", n_ack - b_ack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
